// File: rtl/csr_timer_pkg.sv
// Shared CSR numbers, TCFG field positions and the masked-write merge for the timer block.
package csr_timer_pkg;

  localparam logic [13:0] CSR_TID   = 14'h40;
  localparam logic [13:0] CSR_TCFG  = 14'h41;
  localparam logic [13:0] CSR_TVAL  = 14'h42;
  localparam logic [13:0] CSR_TICLR = 14'h44;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  function automatic logic [31:0] mwrite(input logic [31:0] old_v,
                                         input logic [31:0] wmask,
                                         input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_v);
  endfunction

endpackage

// File: rtl/stable_counter.sv
// 64-bit free-running counter backing rdcntvl/rdcntvh; wraps to 0 after all-ones.
module stable_counter (
  input  logic        clk,
  input  logic        resetn,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_q + 64'd1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_timer.sv
// TID/TCFG/TVAL/TICLR CSRs, down-counting timer and TI interrupt flag.
// Define CSR_STABLE_CNT_EN to build the 64-bit stable counter; otherwise stable_cnt is 0.
module csr_timer
  import csr_timer_pkg::*;
#(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wvalue,
  output logic [31:0] csr_rvalue,
  output logic        csr_hit,
  output logic        timer_int,
  output logic [63:0] stable_cnt,
  output logic [31:0] tid_value
);

  logic [TIMER_W-1:0] tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [31:0]        tid_q, tid_d;
  logic               ti_q, ti_d;

  logic        tcfg_we, tid_we, ticlr_we, fire;
  logic [31:0] tcfg_wr;

  assign tcfg_we  = csr_we && (csr_num == CSR_TCFG);
  assign tid_we   = csr_we && (csr_num == CSR_TID);
  assign ticlr_we = csr_we && (csr_num == CSR_TICLR);
  assign tcfg_wr  = mwrite(32'(tcfg_q), csr_wmask, csr_wvalue);
  assign fire     = tcfg_q[TCFG_EN] && (cnt_q == '0);

  always_comb begin
    tcfg_d = tcfg_q;
    cnt_d  = cnt_q;
    tid_d  = tid_q;
    ti_d   = ti_q;

    if (tid_we) tid_d = mwrite(tid_q, csr_wmask, csr_wvalue);

    // A TCFG write always reloads, even with En cleared, and masks a same-edge expiry.
    if (tcfg_we) begin
      tcfg_d = tcfg_wr[TIMER_W-1:0];
      cnt_d  = {tcfg_wr[TIMER_W-1:2], 2'b00};
    end else if (fire) begin
      cnt_d = tcfg_q[TCFG_PERIODIC] ? {tcfg_q[TIMER_W-1:2], 2'b00} : '1;
    end else if (tcfg_q[TCFG_EN] && (cnt_q != '1)) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end

    if (ticlr_we && csr_wmask[0] && csr_wvalue[0]) ti_d = 1'b0;
    if (fire && !tcfg_we)                          ti_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcfg_q <= '0;
      cnt_q  <= '1;
      tid_q  <= TID_RST;
      ti_q   <= 1'b0;
    end else begin
      tcfg_q <= tcfg_d;
      cnt_q  <= cnt_d;
      tid_q  <= tid_d;
      ti_q   <= ti_d;
    end
  end

  always_comb begin
    csr_rvalue = '0;
    csr_hit    = 1'b1;
    case (csr_num)
      CSR_TID:   csr_rvalue = tid_q;
      CSR_TCFG:  csr_rvalue = 32'(tcfg_q);
      CSR_TVAL:  csr_rvalue = 32'(cnt_q);
      CSR_TICLR: csr_rvalue = '0;
      default:   csr_hit    = 1'b0;
    endcase
  end

  assign timer_int = ti_q;
  assign tid_value = tid_q;

`ifdef CSR_STABLE_CNT_EN
  stable_counter u_stable_counter (
    .clk   (clk),
    .resetn(resetn),
    .cnt_o (stable_cnt)
  );
`else
  assign stable_cnt = '0;
`endif

endmodule
